// File: rtl/spram8_arb.sv
// spram8_arb: two-port arbiter/sequencer in front of the 8-bit single-port RAM.
// Port A (core) has priority; port B (loader/DMA) is forced through after
// MAX_WAIT consecutive denied cycles. Reads return 3 cycles after grant.
// Optional post-reset RAM fill is enabled with the macro SPRAM_ARB_FILL_EN.
module spram8_arb #(
  parameter int             ASZ      = 17,
  parameter int             DSZ      = 8,
  parameter int             DEPTH    = 1 << ASZ,
  parameter int             MAX_WAIT = 4,
  parameter logic [DSZ-1:0] FILL     = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a_req,
  input  logic           a_we,
  input  logic [ASZ-1:0] a_ai,
  input  logic [DSZ-1:0] a_vi,
  output logic           a_gnt,
  output logic           a_rv,
  output logic [DSZ-1:0] a_vo,
  input  logic           b_req,
  input  logic           b_we,
  input  logic [ASZ-1:0] b_ai,
  input  logic [DSZ-1:0] b_vi,
  output logic           b_gnt,
  output logic           b_rv,
  output logic [DSZ-1:0] b_vo,
  output logic [ASZ-1:0] mem_ai,
  output logic           mem_we,
  output logic [DSZ-1:0] mem_vi,
  input  logic [DSZ-1:0] mem_vo,
  output logic           ready
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  // Elaboration-time sanity check on the configuration.
  if (DEPTH < 1 || DEPTH > (1 << ASZ) || MAX_WAIT < 1 || $bits(FILL) != DSZ) begin : g_param_err
    $error("spram8_arb: illegal DEPTH/MAX_WAIT/FILL configuration");
  end

`ifdef SPRAM_ARB_FILL_EN
  typedef enum logic [0:0] {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;
  logic [ASZ:0] r_fill_cnt;
  logic         w_fill_done;
`else
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
`endif

  state_t          r_state;
  state_t          w_state_next;
  logic [WW-1:0]   r_b_wait;
  logic            w_b_force;
  logic            w_a_gnt;
  logic            w_b_gnt;
  logic            r_tag1_v;
  logic            r_tag1_p;
  logic            r_tag2_v;
  logic            r_tag2_p;

  assign ready     = (r_state == ST_RUN);
  assign w_b_force = (r_b_wait == WW'(MAX_WAIT));
  // B wins when alone, or when it has waited long enough; A takes everything else.
  assign w_b_gnt   = rst_n & ready & b_req & (~a_req | w_b_force);
  assign w_a_gnt   = rst_n & ready & a_req & ~w_b_gnt;
  assign a_gnt     = w_a_gnt;
  assign b_gnt     = w_b_gnt;

`ifdef SPRAM_ARB_FILL_EN
  assign w_fill_done = (r_fill_cnt == (ASZ+1)'(DEPTH));

  // Fill address counter; restarts at 0 on every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
    end else if (r_state == ST_FILL && !w_fill_done) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end
`endif

  // Next-state logic: leave the post-reset state once it has done its job.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
`ifdef SPRAM_ARB_FILL_EN
      ST_FILL: if (w_fill_done) w_state_next = ST_RUN;
`else
      ST_INIT: w_state_next = ST_RUN;
`endif
      default: w_state_next = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef SPRAM_ARB_FILL_EN
      r_state <= ST_FILL;
`else
      r_state <= ST_INIT;
`endif
    end else begin
      r_state <= w_state_next;
    end
  end

  // B starvation counter: counts consecutive denied request cycles, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_wait <= '0;
    end else if (!b_req || w_b_gnt) begin
      r_b_wait <= '0;
    end else if (!w_b_force) begin
      r_b_wait <= r_b_wait + WW'(1);
    end
  end

  // Issue stage: register the winning access (or fill write) toward the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ai <= '0;
      mem_we <= 1'b0;
      mem_vi <= '0;
    end else begin
      mem_we <= 1'b0;
`ifdef SPRAM_ARB_FILL_EN
      if (r_state == ST_FILL && !w_fill_done) begin
        mem_ai <= r_fill_cnt[ASZ-1:0];
        mem_vi <= FILL;
        mem_we <= 1'b1;
      end else
`endif
      if (w_a_gnt) begin
        mem_ai <= a_ai;
        mem_vi <= a_vi;
        mem_we <= a_we;
      end else if (w_b_gnt) begin
        mem_ai <= b_ai;
        mem_vi <= b_vi;
        mem_we <= b_we;
      end
    end
  end

  // Read tag pipeline {valid, port}: aligns with RAM data two edges after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag1_v <= 1'b0;
      r_tag1_p <= 1'b0;
      r_tag2_v <= 1'b0;
      r_tag2_p <= 1'b0;
    end else begin
      r_tag1_v <= (w_a_gnt & ~a_we) | (w_b_gnt & ~b_we);
      r_tag1_p <= w_b_gnt;
      r_tag2_v <= r_tag1_v;
      r_tag2_p <= r_tag1_p;
    end
  end

  // Read return: capture RAM data into the originating port and pulse its rv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vo <= '0;
      b_vo <= '0;
      a_rv <= 1'b0;
      b_rv <= 1'b0;
    end else begin
      a_rv <= r_tag2_v & ~r_tag2_p;
      b_rv <= r_tag2_v & r_tag2_p;
      if (r_tag2_v && !r_tag2_p) a_vo <= mem_vo;
      if (r_tag2_v && r_tag2_p)  b_vo <= mem_vo;
    end
  end

endmodule

// File: doc/spram8_arb.md
Name: spram8_arb

Overview:
- Two-requester arbiter and sequencer in front of the 8-bit, 128K single-port RAM (spram8_128k).
- Port A is the eForth1 core (priority); port B is the loader/debug DMA.
- Issues at most one RAM access per cycle, routes read data back to the originating port, and prevents B starvation.
- Optionally fills the RAM with a constant after reset before opening either port.

Parameters:
- ASZ, 17, address width (128K bytes)
- DSZ, 8, data width
- DEPTH, 1<<ASZ, bytes covered by the post-reset fill
- MAX_WAIT, 4, cycles B may be denied while requesting before it is forced to win
- FILL, 8'h00, fill byte

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  port A request, held until a_gnt
- a_we  in  1  port A write (1) / read (0)
- a_ai  in  ASZ  port A address
- a_vi  in  DSZ  port A write data
- a_gnt  out  1  port A grant (combinational)
- a_rv  out  1  port A read-data valid pulse
- a_vo  out  DSZ  port A read data (registered)
- b_req, b_we, b_ai, b_vi, b_gnt, b_rv, b_vo  same as port A, for B
- mem_ai  out  ASZ  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_vi  out  DSZ  RAM write data (registered)
- mem_vo  in  DSZ  RAM read data, valid one cycle after mem_ai is presented
- ready  out  1  arbiter open for requests

Behaviour:
- Reset (rst_n low, async) drives every registered output to 0: mem_ai, mem_we, mem_vi, a_vo, b_vo, a_rv, b_rv, ready.
- Reset also clears b_wait and the read-tag pipeline. a_gnt and b_gnt are forced 0 while rst_n is low or ready is 0.
- Reset asserted mid-operation discards in-flight reads; no rv pulse follows release.
- States:
  - FILL (only with the macro): entered on reset release.
  - RUN: ready=1.
  - Without the macro: ready goes 1 on the first clk edge after release.
- Grant in RUN (combinational, cycle N):
  - Only A requesting: A wins. Only B requesting: B wins.
  - Both requesting: A wins unless b_wait==MAX_WAIT, then B wins.
  - Exactly one gnt is high per cycle; gnt is never high without its req.
- b_wait:
  - Increments each cycle b_req & ~b_gnt, saturating at MAX_WAIT.
  - Clears on b_gnt or ~b_req.
- Issue (edge ending cycle N):
  - The winner's ai/we/vi register into mem_*, so the RAM sees them in N+1.
  - With no winner, mem_we=0 and mem_ai/mem_vi hold their previous values.
  - mem_we is high for exactly one cycle per granted write.
- Requester protocol: the requester may change or drop req/ai/vi in the cycle after its gnt. Back-to-back grants to the same port are allowed (1 access per cycle).
- Read return:
  - A 2-stage tag pipeline {valid, port} follows each granted read.
  - mem_vo (valid in N+2) is captured into x_vo at the edge ending N+2.
  - x_rv pulses in N+3, so the total latency is 3 cycles from grant.
  - x_vo holds until that port's next read return; the other port's vo is unaffected.
- Ordering: accesses execute in grant order. A read granted the cycle after a write to the same address returns the new data.
- No address wrap or width arithmetic beyond ASZ bits; out-of-range inputs cannot occur.

Optional Feature:
- Macro: SPRAM_ARB_FILL_EN.
- Defined:
  - After reset release, the FILL state issues writes of FILL to addresses 0..DEPTH-1, one per cycle.
  - mem_we=1 throughout; address counter is ASZ+1 bits.
  - ready=0 and both gnt=0 during FILL.
  - After the last write, the next cycle enters RUN with ready=1, so ready rises DEPTH+1 cycles after release.
  - Reset during FILL restarts the fill at address 0.
- Undefined: no FILL state and no counter logic; RAM contents after reset are undefined.

Test Plan:
- A only: write 0x1FFFF←0x5A, next cycle read 0x1FFFF → a_gnt high both cycles; a_rv pulses 3 cycles after the read grant with a_vo=0x5A; b_rv stays 0.
- A and B both continuously reading, MAX_WAIT=4 → grant pattern A,A,A,A,B repeating; b_wait reaches 4 exactly in each B-win cycle.
- A writes 0x00010←0x33 in cycle N; B reads 0x00010, granted N+1 → b_rv at N+4 with b_vo=0x33; a_vo unchanged.
- B only, A idle → b_gnt in the first request cycle; b_wait stays 0; a run of writes produces one mem_we pulse per grant.
- Read granted, then rst_n low for 1 cycle before rv → all outputs 0; no a_rv/b_rv after release; ready=1 one edge after release (macro off).
- Macro on, DEPTH=16, FILL=0xA5 → mem_we high 16 cycles over addresses 0..15 with ready=0 and req ignored; ready rises at cycle 17; A read of address 7 returns 0xA5.
